// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding and default timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_BAUD_DIV    = 5208;
  localparam int DEFAULT_WORD_LENGTH = 8;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module      : uart_baud_counter
// Description : Free-running bit-period counter with end-of-bit strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_counter #(
  parameter int BAUD_DIV = uart_pkg::DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] c_pre  = CW'(BAUD_DIV - 2);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_count <= '0;
    else if (clear || bit_tick)
      r_count <= '0;
    else
      r_count <= r_count + CW'(1);
  end

  assign bit_tick = (r_count == c_last);
  // One clock ahead of bit_tick, so callers can register end-of-bit outputs.
  assign pre_tick = (r_count == c_pre);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, LSB-first, optional even parity, 1 stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
  parameter int PARITY_EN   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_start,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int BW = $clog2(WORD_LENGTH);
  localparam logic [BW-1:0] c_last_bit = BW'(WORD_LENGTH - 1);

  uart_state_e            r_state, w_state_n;
  logic [WORD_LENGTH-1:0] r_shift, w_shift_n;
  logic [BW-1:0]          r_bit_cnt, w_bit_cnt_n;
  logic                   r_parity, w_parity_n;
  logic                   w_tx_n, w_busy_n, w_done_n;
  logic                   w_bit_tick, w_pre_tick, w_clear;

  // Counter is held at zero while idle so START begins a full bit period.
  assign w_clear = (r_state == IDLE);

  uart_baud_counter #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .bit_tick (w_bit_tick),
    .pre_tick (w_pre_tick)
  );

  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_bit_cnt_n = r_bit_cnt;
    w_parity_n  = r_parity;
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_state_n   = START;
          w_shift_n   = tx_data;
          w_parity_n  = ^tx_data;
          w_bit_cnt_n = '0;
        end
      end
      START:  if (w_bit_tick) w_state_n = DATA;
      DATA: begin
        if (w_bit_tick) begin
          w_shift_n = r_shift >> 1;
          if (r_bit_cnt == c_last_bit)
            w_state_n = (PARITY_EN != 0) ? PARITY : STOP;
          else
            w_bit_cnt_n = r_bit_cnt + BW'(1);
        end
      end
      PARITY: if (w_bit_tick) w_state_n = STOP;
      STOP:   if (w_bit_tick) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase

    // Outputs are derived from the next state so the registered line
    // changes on the same edge as the state.
    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shift_n[0];
      PARITY:  w_tx_n = w_parity_n;
      default: w_tx_n = 1'b1;
    endcase
    w_busy_n = (w_state_n != IDLE);
    w_done_n = (r_state == STOP) && w_pre_tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_parity  <= w_parity_n;
      tx        <= w_tx_n;
      tx_busy   <= w_busy_n;
      tx_done   <= w_done_n;
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the transmit-side counterpart of the team's UART receive path. It latches a parallel word on a start request and serialises it LSB-first on a single line. The frame is one start bit, WORD_LENGTH data bits, an optional even-parity bit and one stop bit, at a fixed clocks-per-bit rate. It sits between the system-side data source and the TX pin.

Parameters:
WORD_LENGTH, 8, data bits per frame (valid range 5..9)
BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600); minimum 2
PARITY_EN, 0, 1 = append even-parity bit; 0 = no parity bit

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  WORD_LENGTH  word to transmit; sampled only on acceptance
tx_start  input  1  transmit request; level-sensitive, evaluated every cycle
tx  output  1  serial line; idles high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse in the final clock of the stop bit

Behaviour:
- Reset (asynchronous, active-low): tx=1, tx_busy=0, tx_done=0, state IDLE, all counters 0, shift register 0. Asserting reset mid-frame aborts the frame immediately; there is no resumption.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_start=1 at a rising edge: load tx_data into the shift register, compute parity (XOR of tx_data), clear the baud and bit counters, go to START, set tx_busy=1.
  - tx drives 0 from that edge onward, so latency from the accepting edge to tx low is 0 cycles.
- Each of START/DATA/PARITY/STOP lasts exactly BAUD_DIV clocks.
  - Baud counter runs 0..BAUD_DIV-1; the state advances when the counter reaches BAUD_DIV-1.
  - Counter width is clog2(BAUD_DIV).
- START: tx=0 -> DATA.
- DATA:
  - tx = shift register bit 0.
  - At the end of each bit: shift right and increment the bit counter (width clog2(WORD_LENGTH)).
  - After bit WORD_LENGTH-1: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = XOR of latched data (even parity: total ones including the parity bit is even) -> STOP.
- STOP:
  - tx=1.
  - In its last clock, tx_done=1 for exactly one cycle.
  - At the following edge: state IDLE, tx_busy=0, tx_done=0.
- Frame duration: (2 + WORD_LENGTH + PARITY_EN) * BAUD_DIV clocks.
- tx_start while tx_busy=1 is ignored; there is no queuing. Changes on tx_data mid-frame have no effect.
- Back-to-back frames: with tx_start held high, the next frame is accepted in the first IDLE cycle after STOP. This gives exactly 1 idle clock (tx=1) between frames.
- Simultaneous tx_start and tx_done: start is ignored in that cycle and accepted in the next (IDLE) cycle if still high.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum encoding (3-bit: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - the default BAUD_DIV and WORD_LENGTH constants.
  - The receive side reuses the same package.
- Sub-module uart_baud_counter (parameter BAUD_DIV; inputs clk, reset, clear; output bit_tick) produces the end-of-bit strobe. It is shareable with the receiver for its own bit timing.

Test Plan:
1. Assert reset low for 3 clocks, then release -> tx=1, tx_busy=0, tx_done=0 throughout; no transition without tx_start.
2. BAUD_DIV=4, PARITY_EN=1, tx_data=0xA5, tx_start pulsed 1 clock -> tx = 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clocks; tx_done pulses on clock 44; tx_busy high for 44 clocks.
3. During the frame in scenario 2, pulse tx_start with tx_data=0x00 at clock 10 -> waveform unchanged, only one tx_done, tx_busy falls after clock 44.
4. BAUD_DIV=4, PARITY_EN=1: tx_start held high, tx_data=0x01 then changed to 0xFF after first acceptance -> frame 1 parity bit 1, exactly 1 idle-high clock, then frame 2 data all 1s with parity bit 0.
5. Assert reset during data bit 3 of a 0x3C frame -> tx=1 and tx_busy=0 immediately without waiting for a clock; a subsequent tx_start sends a complete correct frame.
6. PARITY_EN=0, BAUD_DIV=4, tx_data=0x80 -> 10-bit frame 0,0,0,0,0,0,0,0,1,1, tx_done on clock 40.
